clock_gate_ctrl: RTL

//  Sequencer for the clock_gating_model cell: merges N_REQ requester clock demands into one enable.

---
 rtl/clock_gate_ctrl_pkg.sv | 13 +
 rtl/clock_gate_ctrl_gating_model.sv | 20 ++
 rtl/clock_gate_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/clock_gate_ctrl_pkg.sv
// Shared definitions for the clock gate sequencer: FSM state encodings and stats width.
package clock_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_WAKE  = 2'b01,
    ST_ON    = 2'b10,
    ST_DRAIN = 2'b11
  } state_e;

  localparam int unsigned STATS_W = 32;

endpackage

// File: rtl/clock_gate_ctrl_gating_model.sv
// Behavioural integrated clock gate: low-phase transparent latch followed by an AND.
// The enable can only change while i_clk is low, so o_clk never carries a partial pulse.
module clock_gating_model (
  input  logic i_clk,
  input  logic i_clock_en,
  output logic o_clk
);

  logic r_en_lat;

  // Capture the enable while the clock is low; hold it through the high phase.
  always_latch begin
    if (!i_clk) begin
      r_en_lat <= i_clock_en;
    end
  end

  assign o_clk = i_clk & r_en_lat;

endmodule

// File: rtl/clock_gate_ctrl.sv
// Clock gate sequencer: merges requester demands into one gating enable, with a wake-up
// settle delay before acknowledging and an idle hysteresis before gating off.
// Optional feature macro: CLK_GATE_CTRL_STATS_EN adds o_gated_cnt (cycles spent in OFF).
module clock_gate_ctrl
  import clock_gate_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_force_on,
  output logic [N_REQ-1:0] o_ack,
  output logic             o_clock_en,
  output logic             o_gclk,
  output logic [1:0]       o_state
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  output logic [STATS_W-1:0] o_gated_cnt
`endif
);

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_wake_cnt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [N_REQ-1:0] r_ack;
  logic             r_clock_en;
  logic             w_any_req;

  assign w_any_req = (|i_req) | i_force_on;

  // Next-state decode; a request in DRAIN beats an expiring idle counter.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_OFF:   if (w_any_req) w_next_state = ST_WAKE;
      ST_WAKE:  if (r_wake_cnt == '0) w_next_state = ST_ON;
      ST_ON:    if (!w_any_req) w_next_state = ST_DRAIN;
      ST_DRAIN: begin
        if (w_any_req) begin
          w_next_state = ST_ON;
        end else if (r_idle_cnt == '0) begin
          w_next_state = ST_OFF;
        end
      end
      default:  w_next_state = ST_OFF;
    endcase
  end

  // FSM state, counters and registered outputs; enable comes from its own flop.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= ST_OFF;
      r_wake_cnt <= '0;
      r_idle_cnt <= '0;
      r_ack      <= '0;
      r_clock_en <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_clock_en <= (w_next_state != ST_OFF);
      r_ack      <= (r_state == ST_ON) ? i_req : '0;
      case (r_state)
        ST_OFF: begin
          if (w_any_req) r_wake_cnt <= WAKE_LOAD;
        end
        ST_WAKE: begin
          if (r_wake_cnt != '0) r_wake_cnt <= r_wake_cnt - 1'b1;
        end
        ST_ON: begin
          if (!w_any_req) r_idle_cnt <= IDLE_LOAD;
        end
        ST_DRAIN: begin
          if (!w_any_req && (r_idle_cnt != '0)) r_idle_cnt <= r_idle_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [STATS_W-1:0] r_gated_cnt;

  // Count edges spent gated off, saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_gated_cnt <= '0;
    end else if ((r_state == ST_OFF) && (r_gated_cnt != '1)) begin
      r_gated_cnt <= r_gated_cnt + 1'b1;
    end
  end

  assign o_gated_cnt = r_gated_cnt;
`endif

  clock_gating_model u_clock_gating_model (
    .i_clk      (i_clk),
    .i_clock_en (o_clock_en),
    .o_clk      (o_gclk)
  );

  assign o_clock_en = r_clock_en;
  assign o_ack      = r_ack;
  assign o_state    = r_state;

endmodule
